// File: rtl/nivel_comida_ctrl_if.sv
// Bus between the pet state machine and the food-level controller.
// The master is the state machine; the slave is the food-level block.
interface nivel_comida_ctrl_if;
  logic [2:0] Visualizacion;
  logic       Senal_MTest;
  logic [1:0] Nivel_Comida;
  logic [7:0] Seg_Restantes;
  logic       Lleno;
  logic       Tick_1s;

  modport master (
    output Visualizacion, Senal_MTest,
    input  Nivel_Comida, Seg_Restantes, Lleno, Tick_1s
  );

  modport slave (
    input  Visualizacion, Senal_MTest,
    output Nivel_Comida, Seg_Restantes, Lleno, Tick_1s
  );
endinterface

// File: rtl/nivel_comida_ctrl.sv
// Food-level generator: decays while idle, refills while eating, freezes in
// manual test mode. Time base is a 1 s tick derived from a clock prescaler.
module nivel_comida_ctrl #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DECAY_SECS = 10,
  parameter int unsigned FEED_SECS  = 2
) (
  input logic                clk,
  input logic                reset,
  nivel_comida_ctrl_if.slave bus
);

  localparam int unsigned PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] DECAY_RLD  = 8'(DECAY_SECS);
  localparam logic [7:0] FEED_MAX   = 8'(FEED_SECS);
  localparam logic [2:0] VIS_COMER  = 3'b011;

  typedef enum logic [1:0] {DECAY, FEED, FROZEN} state_t;

  state_t        state, state_nxt;
  logic          prev_feed;
  logic [PW-1:0] pre, pre_nxt;
  logic [7:0]    feed_cnt;
  logic [7:0]    seg;
  logic [1:0]    nivel;
  logic          tick;
  logic          comer;

  assign comer = (bus.Visualizacion == VIS_COMER);

  // Next state: test mode dominates, then the eating indication.
  always_comb begin
    state_nxt = state;
    if (bus.Senal_MTest) begin
      state_nxt = FROZEN;
    end else begin
      case (state)
        FROZEN:  state_nxt = prev_feed ? FEED : DECAY;
        DECAY:   if (comer) state_nxt = FEED;
        FEED:    if (!comer) state_nxt = DECAY;
        default: state_nxt = DECAY;
      endcase
    end
  end

  // Prescaler only halts once the block is actually frozen.
  always_comb begin
    pre_nxt = pre;
    if (state != FROZEN) pre_nxt = (pre == PRE_MAX) ? '0 : pre + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DECAY;
      prev_feed <= 1'b0;
      pre       <= '0;
      feed_cnt  <= 8'd0;
      seg       <= DECAY_RLD;
      nivel     <= 2'd3;
      tick      <= 1'b0;
    end else begin
      state <= state_nxt;
      pre   <= pre_nxt;
      tick  <= (state_nxt != FROZEN) && (pre_nxt == PRE_MAX);
      if (state != FROZEN && state_nxt == FROZEN) prev_feed <= (state == FEED);

      // A transition swallows any tick landing on the same edge.
      if (state_nxt != state) begin
        if (state == DECAY && state_nxt == FEED) begin
          feed_cnt <= 8'd0;
          seg      <= 8'd0;
        end else if (state == FEED && state_nxt == DECAY) begin
          seg <= (nivel == 2'd0) ? 8'd0 : DECAY_RLD;
        end
      end else if (tick) begin
        case (state)
          DECAY: begin
            if (seg > 8'd1) begin
              seg <= seg - 8'd1;
            end else if (seg == 8'd1) begin
              if (nivel != 2'd0) nivel <= nivel - 2'd1;
              seg <= (nivel <= 2'd1) ? 8'd0 : DECAY_RLD;
            end
          end
          FEED: begin
            if (feed_cnt + 8'd1 >= FEED_MAX) begin
              feed_cnt <= 8'd0;
              if (nivel != 2'd3) nivel <= nivel + 2'd1;
            end else begin
              feed_cnt <= feed_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Nivel_Comida  = nivel;
  assign bus.Seg_Restantes = seg;
  assign bus.Tick_1s       = tick;
  assign bus.Lleno         = (nivel == 2'd3);

endmodule

// File: doc/nivel_comida_ctrl.md
Name: nivel_comida_ctrl

Overview:
- Upstream stage of the pet state machine: generates the 2-bit food level (Nivel_Comida) that the state machine consumes.
- Level decays over time while the pet is not eating.
- Level refills while the state machine reports the eating state (Visualizacion = 3'b011).
- Freezes while manual test mode (Senal_MTest) is active, so test stepping is not disturbed by level changes.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1 s tick (>=2)
- DECAY_SECS, 10, ticks per one-level decrement (1..255)
- FEED_SECS, 2, ticks per one-level increment while eating (1..255)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Visualizacion  input  3  state code from the state machine; 3'b011 = eating
- Senal_MTest  input  1  manual test mode; 1 = freeze
- Nivel_Comida  output  2  food level 0..3
- Seg_Restantes  output  8  ticks remaining until next decrement (0 when level is 0 or while feeding)
- Lleno  output  1  1 when Nivel_Comida == 3
- Tick_1s  output  1  one-cycle pulse per tick

Behaviour:
- Reset is synchronous and active-high, sampled on posedge clk, and has highest priority. On reset:
  - Nivel_Comida=3, Lleno=1, Seg_Restantes=DECAY_SECS, Tick_1s=0
  - prescaler=0, feed counter=0, state=DECAY
- Reset asserted mid-operation (any state) takes effect on the next edge, with the same values.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - Tick_1s=1 for exactly the cycle the count equals TICK_DIV-1.
  - Stops counting (holds its value) in FROZEN.
- States are DECAY, FEED and FROZEN. Transitions are evaluated every edge; priority is reset > Senal_MTest > Visualizacion.
  - any state -> FROZEN when Senal_MTest=1.
  - FROZEN -> previous state (DECAY or FEED, held in a 1-bit register) when Senal_MTest=0. All counters resume from their held values.
  - DECAY -> FEED when Visualizacion==3'b011. On entry: feed counter=0, Seg_Restantes=0.
  - FEED -> DECAY when Visualizacion!=3'b011. On entry: Seg_Restantes=DECAY_SECS, or 0 if Nivel_Comida==0.
- DECAY, on each tick:
  - If Seg_Restantes>1: decrement Seg_Restantes.
  - If Seg_Restantes==1: Nivel_Comida -= 1. Seg_Restantes reloads to DECAY_SECS, or to 0 if the new level is 0.
  - At level 0: Seg_Restantes holds 0 and the level saturates at 0 (no wrap to 3).
- FEED, on each tick:
  - Feed counter increments.
  - When it reaches FEED_SECS: counter=0, and Nivel_Comida += 1 saturating at 3 (no wrap to 0).
  - At level 3: the counter keeps cycling with no effect.
- Simultaneous events:
  - A state transition on the same edge as a tick wins; that tick is not applied to the old or the new state.
  - A tick in the same cycle Senal_MTest rises is discarded.
- Latency:
  - Nivel_Comida changes on the same edge where Tick_1s=1 is sampled.
  - An input change affects state on the first edge after it.
- Outputs are registered except Lleno, which is combinational from Nivel_Comida.
- Arithmetic: widths are fixed as above; the prescaler width is $clog2(TICK_DIV).

Test Plan (TICK_DIV=4, DECAY_SECS=3, FEED_SECS=2):
- Reset for 2 cycles, then release, Visualizacion=0, MTest=0 -> Nivel=3, Lleno=1, Seg=3; Tick_1s pulses every 4 cycles; Seg goes 2,1 and then Nivel=2, Seg=3 at the 3rd tick (cycle 12).
- Run 40 cycles -> Nivel steps to 1 and then 0 at ticks 6 and 9; thereafter Nivel=0, Seg=0 with no wrap to 3.
- At Nivel=0, set Visualizacion=3'b011 -> Seg=0; Nivel=1 after 2 ticks, 2 after 4, 3 after 6 (Lleno=1); remains 3 for 4 more ticks.
- In DECAY at Seg=2, assert MTest for 20 cycles -> Nivel, Seg and prescaler frozen with no Tick_1s; deassert -> the next tick gives Seg=1, and the following tick decrements Nivel.
- Change Visualizacion from 3 to 0 on the exact edge where Tick_1s=1 -> no increment applied; state=DECAY with Seg=DECAY_SECS.
- Assert reset during FEED with Nivel=1 -> next edge Nivel=3, Seg=3, state=DECAY, prescaler=0.
